i2c_slave_rx: RTL
=================

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter MESSAGE_LENGTH, default 8, data byte width in bits.
REQ-002 Parameter SLAVE_ADDR, default 7'h2A, 7-bit bus address this receiver answers to.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scl  input  1  raw I2C clock from the master; asynchronous to clk.
REQ-006 sda_in  input  1  raw I2C data line level; asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release the line.
REQ-008 rx_data  output  MESSAGE_LENGTH  last received data byte, MSB first on the wire.
REQ-009 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-010 selected  output  1  high from address match until STOP or the next START.

Function
REQ-011 scl and sda_in SHALL each pass through a 2-FF synchronizer plus an edge-detect register before use.
REQ-012 START SHALL be a synchronized sda fall while synchronized scl is high; STOP SHALL be a synchronized sda rise while scl is high.
REQ-013 The FSM SHALL use states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE.
REQ-014 START from any state SHALL enter ADDR, clear the bit counter, deassert selected and deassert sda_oe; this covers repeated START.
REQ-015 STOP from any state SHALL enter IDLE, deassert selected and deassert sda_oe.
REQ-016 A START and a STOP detected in the same cycle SHALL be impossible; if both assert, START wins.
REQ-017 In ADDR and DATA, sda SHALL be sampled MSB first on each synchronized scl rising edge, and the bit counter SHALL increment 0..7.
REQ-018 After 8 address bits, when the upper 7 bits equal SLAVE_ADDR and the R/W bit is 0, the FSM SHALL enter ADDR_ACK and assert selected.
REQ-019 After 8 address bits with any other address or with R/W=1, the FSM SHALL enter IGNORE, never drive sda_oe, and wait for START or STOP.
REQ-020 sda_oe SHALL assert on the scl falling edge that follows the 8th rising edge, and SHALL deassert on the next scl falling edge (the end of the 9th clock).
REQ-021 After 8 data bits, rx_data SHALL load the shifted byte and rx_valid SHALL pulse for exactly one clk, 3 clk after the raw scl rise of bit 8; the FSM SHALL then enter DATA_ACK.
REQ-022 From ADDR_ACK or DATA_ACK, the scl falling edge that releases sda_oe SHALL enter DATA with the bit counter at 0, allowing unlimited bytes per transaction.
REQ-023 A STOP or START arriving mid-byte SHALL discard the partial byte with no rx_valid.
REQ-024 The bit counter SHALL wrap only through the state transition and never exceed 7.

Reset
REQ-025 Reset SHALL force state IDLE, bit counter 0, shift register 0, rx_data 0, rx_valid 0, sda_oe 0 and selected 0.
REQ-026 Reset SHALL force all synchronizer flops to 1 (idle bus high).
REQ-027 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously).
REQ-028 After reset the receiver SHALL ignore traffic until the next START.

Structure
REQ-029 Package i2c_pkg SHALL hold the FSM state type, the default MESSAGE_LENGTH (8) and the address width (7).
REQ-030 Sub-module i2c_sync_edge (2-FF sync plus rise/fall outputs) SHALL be instantiated once for scl and once for sda_in.
REQ-031 Target size is 150-300 lines of RTL; the design SHALL contain no combinational path from scl or sda_in to any output.

Verification
REQ-032 START, addr 0x2A+W, byte 8'b01011111, STOP -> ACK on both 9th clocks; rx_data=0x5F; one rx_valid pulse; selected falls at STOP.
REQ-033 START, 0x2A+W, bytes 0x95, 0xF0, 0x0F, STOP -> three rx_valid pulses in order 0x95, 0xF0, 0x0F, with an ACK after each.
REQ-034 START, addr 0x15+W, byte 0x5F -> sda_oe never asserts, no rx_valid, selected stays 0.
REQ-035 START, 0x2A+R -> no ACK, FSM in IGNORE until STOP.
REQ-036 START, 0x2A+W, 4 bits of data, repeated START, 0x2A+W, 0xAA -> the partial byte is dropped and rx_data=0xAA.
REQ-037 Reset pulsed during the ACK clock -> sda_oe drops within the same cycle, and the next full frame is received correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave receiver.
//   MsgLenDefault : default data byte width in bits
//   AddrWidth     : I2C slave address width in bits
//   state_t       : receiver FSM state encoding
package i2c_pkg;

   localparam int unsigned MsgLenDefault = 8;
   localparam int unsigned AddrWidth     = 7;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StData,
      StDataAck,
      StIgnore
   } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect register for one raw bus line.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset; all flops reset to 1 (idle bus high)
//   d_i     : raw asynchronous input
//   level_o : synchronized level
//   rise_o  : one-clk pulse on a synchronized 0->1 transition
//   fall_o  : one-clk pulse on a synchronized 1->0 transition
module i2c_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~prev_q;
   assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver. Answers to SLAVE_ADDR with R/W=0, ACKs the address
// and every data byte, and presents each received byte on rx_data with a rx_valid pulse.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   scl      : raw I2C clock (asynchronous)
//   sda_in   : raw I2C data level (asynchronous)
//   sda_oe   : 1 = pull SDA low (ACK)
//   rx_data  : last received data byte (MSB first on the wire)
//   rx_valid : one-clk pulse when rx_data updates
//   selected : high from address match until STOP or next START
// All outputs are registered; no combinational path from scl/sda_in to an output.
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter int unsigned           MESSAGE_LENGTH = MsgLenDefault,
   parameter logic [AddrWidth-1:0]  SLAVE_ADDR     = 7'h2A
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      scl,
   input  logic                      sda_in,
   output logic                      sda_oe,
   output logic [MESSAGE_LENGTH-1:0] rx_data,
   output logic                      rx_valid,
   output logic                      selected
);

   // Shift register must hold at least the address byte (address + R/W).
   localparam int unsigned ShW  = (MESSAGE_LENGTH > AddrWidth + 1) ? MESSAGE_LENGTH
                                                                   : AddrWidth + 1;
   localparam int unsigned CntW = $clog2(ShW);
   localparam logic [CntW-1:0] AddrLast = CntW'(AddrWidth);
   localparam logic [CntW-1:0] DataLast = CntW'(MESSAGE_LENGTH - 1);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_sync_edge u_scl_sync (
      .clk_i   (clk),
      .rst_i   (reset),
      .d_i     (scl),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_sync_edge u_sda_sync (
      .clk_i   (clk),
      .rst_i   (reset),
      .d_i     (sda_in),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   logic start_det;
   logic stop_det;
   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   state_t                    state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [ShW-1:0]            shift_q, shift_d;
   logic [MESSAGE_LENGTH-1:0] rx_data_q, rx_data_d;
   logic                      rx_valid_q, rx_valid_d;
   logic                      sda_oe_q, sda_oe_d;
   logic                      selected_q, selected_d;

   logic [ShW-1:0] shift_nxt;
   logic           addr_match;

   assign shift_nxt  = {shift_q[ShW-2:0], sda_lvl};
   // Upper 7 bits are the address, LSB is R/W (0 = write).
   assign addr_match = (shift_nxt[AddrWidth:1] == SLAVE_ADDR) && !shift_nxt[0];

   // State register and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         sda_oe_q   <= 1'b0;
         selected_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sda_oe_q   <= sda_oe_d;
         selected_q <= selected_d;
      end
   end

   // Next-state logic. START takes priority over STOP.
   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = StAddr;
      end else if (stop_det) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StAddr: begin
               if (scl_rise && cnt_q == AddrLast) begin
                  state_d = addr_match ? StAddrAck : StIgnore;
               end
            end
            StData: begin
               if (scl_rise && cnt_q == DataLast) begin
                  state_d = StDataAck;
               end
            end
            StAddrAck, StDataAck: begin
               // sda_oe high means this fall ends the 9th clock.
               if (scl_fall && sda_oe_q) begin
                  state_d = StData;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath / output next values.
   always_comb begin
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sda_oe_d   = sda_oe_q;
      selected_d = selected_q;
      if (start_det) begin
         cnt_d      = '0;
         shift_d    = '0;
         sda_oe_d   = 1'b0;
         selected_d = 1'b0;
      end else if (stop_det) begin
         cnt_d      = '0;
         sda_oe_d   = 1'b0;
         selected_d = 1'b0;
      end else begin
         case (state_q)
            StAddr: begin
               if (scl_rise) begin
                  shift_d = shift_nxt;
                  if (cnt_q == AddrLast) begin
                     cnt_d      = '0;
                     selected_d = addr_match;
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end
            end
            StData: begin
               if (scl_rise) begin
                  shift_d = shift_nxt;
                  if (cnt_q == DataLast) begin
                     cnt_d      = '0;
                     rx_data_d  = shift_nxt[MESSAGE_LENGTH-1:0];
                     rx_valid_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end
            end
            StAddrAck, StDataAck: begin
               // First fall after bit 8 asserts ACK, the next one releases it.
               if (scl_fall) begin
                  sda_oe_d = ~sda_oe_q;
               end
            end
            default: sda_oe_d = 1'b0;
         endcase
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign selected = selected_q;

endmodule
